// File: rtl/game_pkg.sv
// game_pkg: shared types and constants for the Flappy Bird game sequencer.
//   game_state_t  : sequencer states, encoding visible on the game_ctrl state port
//   DEF_*         : default frame counts and score width
//   frame_cnt_w() : width of the frame counter able to hold either frame count
package game_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        READY = 3'd1,
        PLAY  = 3'd2,
        DYING = 3'd3,
        OVER  = 3'd4
    } game_state_t;

    localparam int DEF_READY_FRAMES = 30;
    localparam int DEF_DEATH_FRAMES = 90;
    localparam int DEF_SCORE_W      = 8;

    // Width that holds max(a, b). It is never below 1 bit, so both counts
    // at zero still give a legal vector.
    function automatic int frame_cnt_w(input int a, input int b);
        int m;
        m = (a > b) ? a : b;
        if (m < 1) begin
            m = 1;
        end
        return $clog2(m + 1);
    endfunction

endpackage

// File: rtl/btn_sync_edge.sv
// btn_sync_edge: two-flop synchronizer for an asynchronous board button,
// followed by a rising-edge detector.
//   clk   : system clock
//   reset : synchronous, active-high; clears every flop
//   btn   : raw button level, asynchronous to clk
//   pulse : one-cycle pulse, high in the third cycle after the raw rise
module btn_sync_edge (
    input  logic clk,
    input  logic reset,
    input  logic btn,
    output logic pulse
);

    logic sync1_reg;
    logic sync2_reg;
    logic prev_reg;

    always_ff @(posedge clk) begin
        if (reset) begin
            sync1_reg <= 1'b0;
            sync2_reg <= 1'b0;
            prev_reg  <= 1'b0;
        end else begin
            sync1_reg <= btn;
            sync2_reg <= sync1_reg;
            prev_reg  <= sync2_reg;
        end
    end

    // Built only from flops, so the pulse is glitch-free.
    assign pulse = sync2_reg & ~prev_reg;

endmodule

// File: rtl/game_ctrl.sv
// game_ctrl: top-level game sequencer (IDLE -> READY -> PLAY -> DYING -> OVER).
// It gates the pipe scroller and bird physics, masks the die detector between
// rounds, and keeps the round score and the high score.
//   clk, reset  : system clock, synchronous active-high reset
//   frame_tick  : one pulse per video frame; drives the READY/DYING countdowns
//   flap_btn    : raw button level (synchronized internally)
//   die         : collision level; pipe_pass: pipe passed the bird column
//   run         : scroll/physics enable;   flap : one-cycle flap impulse
//   world_rst   : one-cycle world reset;   die_clr : die detector clear/mask
//   game_over   : high in OVER;            state : current state encoding
//   score       : round score (saturating); hiscore : best score since reset
// Build option: define GAME_HISCORE_EN to build the high-score register.
// Without it, hiscore is tied to 0.
// Every output is a register. Each output's next value is decoded from the
// next state, so a state change and its outputs take effect on the same edge.
module game_ctrl
    import game_pkg::*;
#(
    parameter int READY_FRAMES = DEF_READY_FRAMES,
    parameter int DEATH_FRAMES = DEF_DEATH_FRAMES,
    parameter int SCORE_W      = DEF_SCORE_W
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               frame_tick,
    input  logic               flap_btn,
    input  logic               die,
    input  logic               pipe_pass,
    output logic               run,
    output logic               flap,
    output logic               world_rst,
    output logic               die_clr,
    output logic               game_over,
    output logic [2:0]         state,
    output logic [SCORE_W-1:0] score,
    output logic [SCORE_W-1:0] hiscore
);

    localparam int FCNT_W = frame_cnt_w(READY_FRAMES, DEATH_FRAMES);
    localparam logic [FCNT_W-1:0]  READY_CNT = FCNT_W'(READY_FRAMES);
    localparam logic [FCNT_W-1:0]  DEATH_CNT = FCNT_W'(DEATH_FRAMES);
    localparam logic [SCORE_W-1:0] SCORE_MAX = '1;

    logic btn_edge;

    btn_sync_edge u_btn (
        .clk   (clk),
        .reset (reset),
        .btn   (flap_btn),
        .pulse (btn_edge)
    );

    game_state_t        state_reg, state_next;
    logic [FCNT_W-1:0]  cnt_reg, cnt_next;
    logic [SCORE_W-1:0] score_reg, score_next;
    logic               run_reg, run_next;
    logic               flap_reg, flap_next;
    logic               world_rst_reg, world_rst_next;
    logic               die_clr_reg, die_clr_next;
    logic               game_over_reg, game_over_next;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg     <= IDLE;
            cnt_reg       <= '0;
            score_reg     <= '0;
            run_reg       <= 1'b0;
            flap_reg      <= 1'b0;
            world_rst_reg <= 1'b0;
            die_clr_reg   <= 1'b1;
            game_over_reg <= 1'b0;
        end else begin
            state_reg     <= state_next;
            cnt_reg       <= cnt_next;
            score_reg     <= score_next;
            run_reg       <= run_next;
            flap_reg      <= flap_next;
            world_rst_reg <= world_rst_next;
            die_clr_reg   <= die_clr_next;
            game_over_reg <= game_over_next;
        end
    end

    always_comb begin
        state_next     = state_reg;
        cnt_next       = cnt_reg;
        score_next     = score_reg;
        flap_next      = 1'b0;
        world_rst_next = 1'b0;

        case (state_reg)
            IDLE, OVER: begin
                if (btn_edge) begin
                    state_next     = READY;
                    world_rst_next = 1'b1;
                    score_next     = '0;
                    cnt_next       = READY_CNT;
                end
            end
            READY: begin
                if (frame_tick) begin
                    if (cnt_reg == '0) begin
                        state_next = PLAY;
                    end else begin
                        cnt_next = cnt_reg - FCNT_W'(1);
                    end
                end
            end
            PLAY: begin
                // A collision takes priority over a simultaneous pipe pass
                // or flap, so nothing leaks into DYING.
                if (die) begin
                    state_next = DYING;
                    cnt_next   = DEATH_CNT;
                end else begin
                    if (pipe_pass && (score_reg != SCORE_MAX)) begin
                        score_next = score_reg + SCORE_W'(1);
                    end
                    flap_next = btn_edge;
                end
            end
            DYING: begin
                if (frame_tick) begin
                    if (cnt_reg == '0) begin
                        state_next = OVER;
                    end else begin
                        cnt_next = cnt_reg - FCNT_W'(1);
                    end
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase

        run_next       = (state_next == PLAY);
        // The die detector stays cleared from power-up until play starts. It
        // is released through PLAY/DYING/OVER, so leaving OVER pulses it.
        die_clr_next   = (state_next == IDLE) || (state_next == READY);
        game_over_next = (state_next == OVER);
    end

`ifdef GAME_HISCORE_EN
    logic [SCORE_W-1:0] hiscore_reg;
    logic               round_end;

    assign round_end = (state_reg == DYING) && frame_tick && (cnt_reg == '0);

    always_ff @(posedge clk) begin
        if (reset) begin
            hiscore_reg <= '0;
        end else if (round_end && (score_reg > hiscore_reg)) begin
            hiscore_reg <= score_reg;
        end
    end

    assign hiscore = hiscore_reg;
`else
    assign hiscore = '0;
`endif

    assign state     = state_reg;
    assign score     = score_reg;
    assign run       = run_reg;
    assign flap      = flap_reg;
    assign world_rst = world_rst_reg;
    assign die_clr   = die_clr_reg;
    assign game_over = game_over_reg;

endmodule

// File: tb/tb_game_ctrl.sv
// Table-driven bench for game_ctrl, run with READY_FRAMES=3, DEATH_FRAMES=2.
// Each table row gives one cycle of inputs plus the registered outputs
// expected after the following clock edge. The driver pushes the
// expectation into a scoreboard queue. The checker pops it 1 ns after
// that edge.
module tb_game_ctrl;

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_READY = 3'd1;
    localparam logic [2:0] S_PLAY  = 3'd2;
    localparam logic [2:0] S_DYING = 3'd3;
    localparam logic [2:0] S_OVER  = 3'd4;

`ifdef GAME_HISCORE_EN
    localparam logic [7:0] H5 = 8'd5;
`else
    localparam logic [7:0] H5 = 8'd0;
`endif

    typedef struct packed {
        logic [2:0] st;
        logic       run;
        logic       flap;
        logic       wrst;
        logic       dclr;
        logic       gover;
        logic [7:0] score;
        logic [7:0] hi;
    } out_t;

    typedef struct packed {
        logic rst;
        logic tick;
        logic btn;
        logic die;
        logic pp;
        out_t exp;
    } row_t;

    typedef struct packed {
        int   idx;
        out_t exp;
    } sb_t;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       frame_tick = 1'b0;
    logic       flap_btn = 1'b0;
    logic       die = 1'b0;
    logic       pipe_pass = 1'b0;
    logic       run, flap, world_rst, die_clr, game_over;
    logic [2:0] state;
    logic [7:0] score, hiscore;

    row_t tbl[$];
    sb_t  sb_q[$];
    int   checks = 0;
    int   passes = 0;

    game_ctrl #(
        .READY_FRAMES (3),
        .DEATH_FRAMES (2),
        .SCORE_W      (8)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .frame_tick (frame_tick),
        .flap_btn   (flap_btn),
        .die        (die),
        .pipe_pass  (pipe_pass),
        .run        (run),
        .flap       (flap),
        .world_rst  (world_rst),
        .die_clr    (die_clr),
        .game_over  (game_over),
        .state      (state),
        .score      (score),
        .hiscore    (hiscore)
    );

    always #5 clk = ~clk;

    // Level outputs follow the state directly: run only in PLAY, die_clr in
    // IDLE/READY, and game_over only in OVER.
    task automatic add(input logic rst, input logic tick, input logic btn,
                       input logic d, input logic pp, input logic [2:0] st,
                       input logic fl, input logic wr, input int sc,
                       input logic [7:0] hi);
        row_t r;
        r.rst       = rst;
        r.tick      = tick;
        r.btn       = btn;
        r.die       = d;
        r.pp        = pp;
        r.exp.st    = st;
        r.exp.run   = (st == S_PLAY);
        r.exp.flap  = fl;
        r.exp.wrst  = wr;
        r.exp.dclr  = (st == S_IDLE) || (st == S_READY);
        r.exp.gover = (st == S_OVER);
        r.exp.score = 8'(sc);
        r.exp.hi    = hi;
        tbl.push_back(r);
    endtask

    // Scoreboard checker: one line per compared cycle.
    always @(posedge clk) begin
        #1;
        if (sb_q.size() > 0) begin
            sb_t  e;
            out_t got;
            e   = sb_q.pop_front();
            got = '{state, run, flap, world_rst, die_clr, game_over, score, hiscore};
            checks++;
            if (got !== e.exp) begin
                $display("FAIL row%0d: got st=%0d run=%b flap=%b wrst=%b dclr=%b gover=%b score=%0d hi=%0d, exp st=%0d run=%b flap=%b wrst=%b dclr=%b gover=%b score=%0d hi=%0d",
                         e.idx, got.st, got.run, got.flap, got.wrst, got.dclr,
                         got.gover, got.score, got.hi, e.exp.st, e.exp.run,
                         e.exp.flap, e.exp.wrst, e.exp.dclr, e.exp.gover,
                         e.exp.score, e.exp.hi);
            end else begin
                passes++;
                $display("row%0d ok: st=%0d score=%0d hi=%0d", e.idx, got.st,
                         got.score, got.hi);
            end
        end
    end

    initial begin
        // Reset state
        add(1,0,0,0,0, S_IDLE,0,0,0,0);
        add(1,0,0,0,0, S_IDLE,0,0,0,0);
        // Round 1: the button rises here; world_rst fires in cycle 4
        add(0,0,1,0,0, S_IDLE,0,0,0,0);
        add(0,0,1,0,0, S_IDLE,0,0,0,0);
        add(0,0,1,0,0, S_READY,0,1,0,0);
        add(0,0,0,1,0, S_READY,0,0,0,0);   // die masked in READY
        add(0,1,0,0,0, S_READY,0,0,0,0);
        add(0,1,0,0,0, S_READY,0,0,0,0);
        add(0,1,0,0,0, S_READY,0,0,0,0);
        add(0,1,0,0,0, S_PLAY,0,0,0,0);    // 4th tick -> PLAY
        for (int i = 1; i <= 5; i++) add(0,0,0,0,1, S_PLAY,0,0,i,0);
        add(0,0,1,0,0, S_PLAY,0,0,5,0);
        add(0,0,1,0,0, S_PLAY,0,0,5,0);
        add(0,0,1,0,0, S_PLAY,1,0,5,0);    // one flap pulse
        add(0,0,1,0,0, S_PLAY,0,0,5,0);
        add(0,0,0,0,0, S_PLAY,0,0,5,0);
        add(0,0,0,1,1, S_DYING,0,0,5,0);   // die beats pipe_pass
        add(0,0,1,0,1, S_DYING,0,0,5,0);
        add(0,0,1,0,0, S_DYING,0,0,5,0);
        add(0,1,1,0,0, S_DYING,0,0,5,0);   // btn edge ignored, tick 1
        add(0,0,0,0,1, S_DYING,0,0,5,0);
        add(0,1,0,0,0, S_DYING,0,0,5,0);   // tick 2
        add(0,1,0,0,0, S_OVER,0,0,5,H5);   // tick 3 -> OVER
        // Round 2: ends with score 3, hiscore stays at 5
        add(0,0,1,0,0, S_OVER,0,0,5,H5);
        add(0,0,1,0,0, S_OVER,0,0,5,H5);
        add(0,0,1,0,0, S_READY,0,1,0,H5);
        add(0,0,0,0,0, S_READY,0,0,0,H5);
        add(0,1,0,0,0, S_READY,0,0,0,H5);
        add(0,1,0,0,0, S_READY,0,0,0,H5);
        add(0,1,0,0,0, S_READY,0,0,0,H5);
        add(0,1,0,0,0, S_PLAY,0,0,0,H5);
        for (int i = 1; i <= 3; i++) add(0,0,0,0,1, S_PLAY,0,0,i,H5);
        add(0,0,0,1,0, S_DYING,0,0,3,H5);
        add(0,1,0,0,0, S_DYING,0,0,3,H5);
        add(0,1,0,0,0, S_DYING,0,0,3,H5);
        add(0,1,0,0,0, S_OVER,0,0,3,H5);
        // Round 3: score saturates at 255, then reset mid-PLAY
        add(0,0,1,0,0, S_OVER,0,0,3,H5);
        add(0,0,1,0,0, S_OVER,0,0,3,H5);
        add(0,0,1,0,0, S_READY,0,1,0,H5);
        add(0,0,0,0,0, S_READY,0,0,0,H5);
        add(0,1,0,0,0, S_READY,0,0,0,H5);
        add(0,1,0,0,0, S_READY,0,0,0,H5);
        add(0,1,0,0,0, S_READY,0,0,0,H5);
        add(0,1,0,0,0, S_PLAY,0,0,0,H5);
        for (int i = 1; i <= 260; i++)
            add(0,0,0,0,1, S_PLAY,0,0,(i > 255) ? 255 : i,H5);
        add(1,0,0,0,1, S_IDLE,0,0,0,0);    // reset clears hiscore too
        add(0,0,0,0,0, S_IDLE,0,0,0,0);

        for (int i = 0; i < tbl.size(); i++) begin
            sb_t s;
            @(negedge clk);
            reset      = tbl[i].rst;
            frame_tick = tbl[i].tick;
            flap_btn   = tbl[i].btn;
            die        = tbl[i].die;
            pipe_pass  = tbl[i].pp;
            s.idx      = i;
            s.exp      = tbl[i].exp;
            sb_q.push_back(s);
        end
        @(negedge clk);
        reset = 1'b0; frame_tick = 1'b0; flap_btn = 1'b0;
        die = 1'b0; pipe_pass = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if (sb_q.size() != 0)
            $display("FAIL scoreboard_drain: got %0d pending, exp 0", sb_q.size());
        else
            passes++;
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
